cb_filter_gate: RTL and testbench

CB_FILTER_GATE -- requirements
Module: cb_filter_gate

---
 rtl/cb_filter_gate.sv | 111 +++++++++++
 tb/tb_cb_filter_gate.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cb_filter_gate.sv
// Counting-filter admission gate: blocks keys that may already be in flight, tracks issued keys
// in an in-order FIFO and drives filter insert/remove/clear. Optional CB_FILTER_GATE_ERR_EN adds a sticky error flag.
module cb_filter_gate #(
   parameter int InpWidth = 32,
   parameter int Depth    = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [InpWidth-1:0]        req_data_i,
   output logic                       req_valid_o,
   input  logic                       req_ready_i,
   output logic [InpWidth-1:0]        req_data_o,
   input  logic                       rsp_valid_i,
   input  logic                       flush_i,
   output logic [InpWidth-1:0]        flt_look_data_o,
   input  logic                       flt_look_valid_i,
   output logic [InpWidth-1:0]        flt_incr_data_o,
   output logic                       flt_incr_valid_o,
   output logic [InpWidth-1:0]        flt_decr_data_o,
   output logic                       flt_decr_valid_o,
   output logic                       flt_clear_o,
   input  logic                       flt_full_i,
   output logic [$clog2(Depth):0]     outstanding_o,
   output logic                       busy_o,
   output logic                       err_o
);
   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] CLEAR = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [InpWidth-1:0] mem [Depth];
   logic                fifo_full, fifo_empty, pass, push, pop;

   assign fifo_full  = (cnt_q == CntW'(Depth));
   assign fifo_empty = (cnt_q == '0);

   // rst_ni gates pass so the handshake outputs read 0 while reset is held
   assign pass = rst_ni & (state_q == RUN) & ~flt_look_valid_i & ~fifo_full & ~flt_full_i;
   assign push = req_valid_i & req_ready_i & pass;
   assign pop  = rsp_valid_i & ~fifo_empty;

   assign req_valid_o      = req_valid_i & pass;
   assign req_ready_o      = req_ready_i & pass;
   assign req_data_o       = req_data_i;
   assign flt_look_data_o  = req_data_i;
   assign flt_incr_valid_o = push;
   assign flt_incr_data_o  = req_data_i;
   assign flt_decr_valid_o = pop;
   assign flt_decr_data_o  = mem[rd_ptr_q];
   assign flt_clear_o      = (state_q == CLEAR);
   assign busy_o           = (state_q != RUN);
   assign outstanding_o    = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // DRAIN exits on the post-pop occupancy so CLEAR follows the last pop directly
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (flush_i) state_d = DRAIN;
         DRAIN:   if (cnt_d == '0) state_d = CLEAR;
         CLEAR:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= RUN;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= req_data_i;
   end

`ifdef CB_FILTER_GATE_ERR_EN
   logic err_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else if ((rsp_valid_i & fifo_empty) | (flt_full_i & ~fifo_full)) err_q <= 1'b1;
   end
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cb_filter_gate.sv
// Scoreboard bench for cb_filter_gate: driver pushes per-cycle expectations from a queue-based
// reference model, a negedge monitor pops and compares them against the DUT.
module tb_cb_filter_gate;
   localparam int W = 32;
   localparam int D = 8;
`ifdef CB_FILTER_GATE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0;
   logic req_valid_i = 0, req_ready_i = 0, rsp_valid_i = 0, flush_i = 0;
   logic look_i = 0, full_i = 0;
   logic [W-1:0] req_data_i = '0;
   logic req_ready_o, req_valid_o, incr_v, decr_v, clear_o, busy_o, err_o;
   logic [W-1:0] req_data_o, look_d, incr_d, decr_d;
   logic [$clog2(D):0] outstanding_o;

   cb_filter_gate #(.InpWidth(W), .Depth(D)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
      .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_data_o(req_data_o),
      .rsp_valid_i(rsp_valid_i), .flush_i(flush_i),
      .flt_look_data_o(look_d), .flt_look_valid_i(look_i),
      .flt_incr_data_o(incr_d), .flt_incr_valid_o(incr_v),
      .flt_decr_data_o(decr_d), .flt_decr_valid_o(decr_v),
      .flt_clear_o(clear_o), .flt_full_i(full_i),
      .outstanding_o(outstanding_o), .busy_o(busy_o), .err_o(err_o));

   always #5 clk = ~clk;

   typedef struct {
      bit rv, rr, iv, dv, clr, busy, err;
      logic [W-1:0] rdata, idata, ddata;
      int outst;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0, errors = 0;

   // reference model state
   logic [W-1:0] keys[$];
   bit draining = 0, clearing = 0, m_err = 0;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // one cycle of stimulus; expectation computed from the model, then the model advances
   task automatic cyc(input bit rst, input bit rv, input logic [W-1:0] data, input bit rr,
                      input bit look, input bit full, input bit rsp, input bit flush);
      exp_t e;
      bit pass, hs;
      @(posedge clk); #1;
      rst_n = ~rst; req_valid_i = rv; req_data_i = data; req_ready_i = rr;
      look_i = look; full_i = full; rsp_valid_i = rsp; flush_i = flush;
      if (rst) begin
         keys.delete(); draining = 0; clearing = 0; m_err = 0;
      end
      pass = !rst && !draining && !clearing && !look && keys.size() < D && !full;
      hs = rv && rr && pass;
      e.rv = rv && pass; e.rr = rr && pass; e.rdata = data;
      e.iv = hs; e.idata = data;
      e.dv = !rst && rsp && keys.size() > 0;
      e.ddata = e.dv ? keys[0] : '0;
      e.clr = clearing; e.busy = draining || clearing;
      e.err = m_err; e.outst = keys.size();
      exp_q.push_back(e);
      if (!rst) begin
         if (ERR_EN && ((rsp && keys.size() == 0) || (full && keys.size() < D))) m_err = 1;
         if (e.dv) void'(keys.pop_front());
         if (hs) keys.push_back(data);
         if (clearing) clearing = 0;
         else if (draining) begin
            if (keys.size() == 0) begin draining = 0; clearing = 1; end
         end else if (flush) draining = 1;
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("req_valid_o", req_valid_o, e.rv);
         chk("req_ready_o", req_ready_o, e.rr);
         chk("req_data_o", req_data_o, e.rdata);
         chk("look_data", look_d, e.rdata);
         chk("incr_valid", incr_v, e.iv);
         if (e.iv) chk("incr_data", incr_d, e.idata);
         chk("decr_valid", decr_v, e.dv);
         if (e.dv) chk("decr_data", decr_d, e.ddata);
         chk("flt_clear", clear_o, e.clr);
         chk("busy", busy_o, e.busy);
         chk("err", err_o, e.err);
         chk("outstanding", outstanding_o, e.outst);
      end
   end

   initial begin
      // reset with request inputs high: gate outputs must read 0
      cyc(1, 1, 32'h1, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      // keys 0xA, 0xB then two responses
      cyc(0, 1, 32'hA, 1, 0, 0, 0, 0);
      cyc(0, 1, 32'hB, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      // lookup hit blocks the request
      cyc(0, 1, 32'hC, 1, 1, 0, 0, 0);
      // fill to Depth, 9th blocked, push with pop at full is blocked
      for (int i = 0; i < D; i++) cyc(0, 1, 32'h100 + i, 1, 0, 0, 0, 0);
      cyc(0, 1, 32'h200, 1, 0, 0, 0, 0);
      cyc(0, 1, 32'h201, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < D - 1; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
      // flush with 3 outstanding
      for (int i = 0; i < 3; i++) cyc(0, 1, 32'h300 + i, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 1, 32'h400, 1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 32'h500 + i, 1, 0, 0, 0, 0);
      // response on empty fifo, then a held flush with nothing outstanding
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++)
         cyc(0, $urandom_range(9, 0) < 7, $urandom, $urandom_range(9, 0) < 8,
             $urandom_range(9, 0) < 2, $urandom_range(19, 0) == 0,
             $urandom_range(9, 0) < 4, $urandom_range(39, 0) == 0);
      // reset with 4 outstanding
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 32'h600 + i, 1, 0, 0, 0, 0);
      cyc(1, 1, 32'h700, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 1, 32'h800, 1, 0, 0, 0, 0);
      @(negedge clk); #1;
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
